// File: rtl/lemming_if.sv
// Per-lane stimulus and status bundle for the lemming walker array.
// The master side drives the lane inputs; the slave side reports the lane states.
interface lemming_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned AW = $clog2(N + 1);

  logic [N-1:0]  bump_left;
  logic [N-1:0]  bump_right;
  logic [N-1:0]  ground;
  logic [N-1:0]  dig;
  logic [N-1:0]  walk_left;
  logic [N-1:0]  walk_right;
  logic [N-1:0]  aaah;
  logic [N-1:0]  digging;
  logic [N-1:0]  splat;
  logic [AW-1:0] alive_cnt;

  modport master (
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging, splat, alive_cnt
  );

  modport slave (
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging, splat, alive_cnt
  );
endinterface

// File: rtl/lemming_array.sv
// N independent Moore lemming walkers with a fall-length splat rule and a
// registered count of lanes still alive.
module lemming_array #(
  parameter int unsigned N            = 4,
  parameter int unsigned SPLAT_CYCLES = 20,
  parameter int unsigned CNT_W        = $clog2(SPLAT_CYCLES + 2)
) (
  input logic      clk,
  input logic      reset,
  lemming_if.slave bus
);
  localparam int unsigned AW = $clog2(N + 1);
  // Fall counter saturates here; reaching it means the lane is past the survival bound.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SPLAT_CYCLES + 1);

  typedef enum logic [2:0] {
    StWalkL, StWalkR, StFallL, StFallR, StDigL, StDigR, StSplat
  } state_e;

  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [AW-1:0]    alive_q, alive_d;

  logic [N-1:0] walk_left, walk_right, aaah, digging, splat;

  always_comb begin
    alive_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StWalkL: begin
          if (!bus.ground[i]) begin
            state_d[i] = StFallL;
            cnt_d[i]   = CNT_W'(1);
          end else if (bus.dig[i]) begin
            state_d[i] = StDigL;
          end else if (bus.bump_left[i]) begin
            state_d[i] = StWalkR;
          end
        end
        StWalkR: begin
          if (!bus.ground[i]) begin
            state_d[i] = StFallR;
            cnt_d[i]   = CNT_W'(1);
          end else if (bus.dig[i]) begin
            state_d[i] = StDigR;
          end else if (bus.bump_right[i]) begin
            state_d[i] = StWalkL;
          end
        end
        StDigL, StDigR: begin
          if (!bus.ground[i]) begin
            state_d[i] = (state_q[i] == StDigL) ? StFallL : StFallR;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        StFallL, StFallR: begin
          if (!bus.ground[i]) begin
            if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StSplat;
          end else begin
            state_d[i] = (state_q[i] == StFallL) ? StWalkL : StWalkR;
          end
        end
        StSplat: state_d[i] = StSplat;
        default: state_d[i] = StWalkL;
      endcase
      if (state_d[i] != StSplat) alive_d = alive_d + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= StWalkL;
        cnt_q[i]   <= '0;
      end
      alive_q <= AW'(N);
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      alive_q <= alive_d;
    end
  end

  always_comb begin
    walk_left  = '0;
    walk_right = '0;
    aaah       = '0;
    digging    = '0;
    splat      = '0;
    for (int i = 0; i < N; i++) begin
      walk_left[i]  = (state_q[i] == StWalkL);
      walk_right[i] = (state_q[i] == StWalkR);
      aaah[i]       = (state_q[i] == StFallL) || (state_q[i] == StFallR);
      digging[i]    = (state_q[i] == StDigL) || (state_q[i] == StDigR);
      splat[i]      = (state_q[i] == StSplat);
    end
  end

  assign bus.walk_left  = walk_left;
  assign bus.walk_right = walk_right;
  assign bus.aaah       = aaah;
  assign bus.digging    = digging;
  assign bus.splat      = splat;
  assign bus.alive_cnt  = alive_q;
endmodule

// File: tb/tb_lemming_array.sv
// Bench for lemming_array: directed scenarios plus random stimulus, all checked
// against a lane-level behavioural model of walking, digging, falling and splatting.
module tb_lemming_array;
  localparam int unsigned N            = 4;
  localparam int unsigned SPLAT_CYCLES = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lemming_if #(.N(N)) bus ();

  lemming_array #(.N(N), .SPLAT_CYCLES(SPLAT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: mode 0 walk, 1 fall, 2 dig, 3 dead; dir 0 left, 1 right.
  int m_mode [N];
  int m_dir  [N];
  int m_flen [N];
  int hole   [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_mode[i] = 0;
        m_dir[i]  = 0;
        m_flen[i] = 0;
      end else begin
        case (m_mode[i])
          0: begin
            if (!bus.ground[i]) begin
              m_mode[i] = 1;
              m_flen[i] = 1;
            end else if (bus.dig[i]) m_mode[i] = 2;
            else if (m_dir[i] == 0 && bus.bump_left[i]) m_dir[i] = 1;
            else if (m_dir[i] == 1 && bus.bump_right[i]) m_dir[i] = 0;
          end
          2: begin
            if (!bus.ground[i]) begin
              m_mode[i] = 1;
              m_flen[i] = 1;
            end
          end
          1: begin
            if (!bus.ground[i]) m_flen[i]++;
            else if (m_flen[i] > int'(SPLAT_CYCLES)) m_mode[i] = 3;
            else m_mode[i] = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_wl, e_wr, e_aa, e_dg, e_sp;
    int e_alive;
    e_wl = '0; e_wr = '0; e_aa = '0; e_dg = '0; e_sp = '0;
    e_alive = 0;
    for (int i = 0; i < N; i++) begin
      e_wl[i] = (m_mode[i] == 0) && (m_dir[i] == 0);
      e_wr[i] = (m_mode[i] == 0) && (m_dir[i] == 1);
      e_aa[i] = (m_mode[i] == 1);
      e_dg[i] = (m_mode[i] == 2);
      e_sp[i] = (m_mode[i] == 3);
      if (m_mode[i] != 3) e_alive++;
    end
    check_eq("walk_left",  bus.walk_left,  e_wl);
    check_eq("walk_right", bus.walk_right, e_wr);
    check_eq("aaah",       bus.aaah,       e_aa);
    check_eq("digging",    bus.digging,    e_dg);
    check_eq("splat",      bus.splat,      e_sp);
    check_eq("alive_cnt",  bus.alive_cnt,  e_alive);
    for (int i = 0; i < N; i++) begin
      check_eq("one_hot", $countones({bus.walk_left[i], bus.walk_right[i], bus.aaah[i],
                                      bus.digging[i], bus.splat[i]}), 1);
    end
    check_eq("alive_vs_splat", bus.alive_cnt, N - $countones(bus.splat));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.bump_left  = '0;
    bus.bump_right = '0;
    bus.ground     = '1;
    bus.dig        = '0;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_dir[i] = 0; m_flen[i] = 0; hole[i] = 0;
    end
    #1;

    // Reset and walk
    tick();
    reset = 1'b0;
    check_eq("rst_walk_left", bus.walk_left, 4'hF);
    check_eq("rst_alive", bus.alive_cnt, 4);
    bus.bump_left = 4'h4;
    tick();
    bus.bump_left = '0;
    check_eq("bump_walk_right", bus.walk_right, 4'h4);
    check_eq("bump_walk_left", bus.walk_left, 4'hB);

    // Priority on lane 0 in WALK_R
    bus.bump_left[0] = 1'b1;
    tick();
    bus.bump_left[0]  = 1'b0;
    bus.ground[0]     = 1'b0;
    bus.dig[0]        = 1'b1;
    bus.bump_right[0] = 1'b1;
    tick();
    check_eq("prio_fall", bus.aaah[0], 1);
    bus.ground[0] = 1'b1; bus.dig[0] = 1'b0; bus.bump_right[0] = 1'b0;
    tick();
    check_eq("keep_dir_right", bus.walk_right[0], 1);

    // Dig then fall on lane 1
    bus.dig[1] = 1'b1;
    tick();
    bus.dig[1] = 1'b0;
    check_eq("dig_start", bus.digging[1], 1);
    bus.bump_left[1] = 1'b1; bus.bump_right[1] = 1'b1;
    ticks(5);
    check_eq("dig_hold", bus.digging[1], 1);
    bus.bump_left[1] = 1'b0; bus.bump_right[1] = 1'b0;
    bus.ground[1] = 1'b0;
    tick();
    check_eq("dig_fall", bus.aaah[1], 1);
    bus.ground[1] = 1'b1;
    tick();
    check_eq("dig_land_left", bus.walk_left[1], 1);

    // Lane 0: turn left, then fall exactly SPLAT_CYCLES cycles
    bus.bump_right[0] = 1'b1;
    tick();
    bus.bump_right[0] = 1'b0;
    bus.ground[0] = 1'b0;
    ticks(SPLAT_CYCLES);
    bus.ground[0] = 1'b1;
    tick();
    check_eq("survive_20", bus.walk_left[0], 1);

    // Lane 3: fall one cycle too long
    bus.ground[3] = 1'b0;
    ticks(SPLAT_CYCLES + 1);
    check_eq("alive_before_splat", bus.alive_cnt, 4);
    bus.ground[3] = 1'b1;
    tick();
    check_eq("splat_21", bus.splat[3], 1);
    check_eq("alive_after_splat", bus.alive_cnt, 3);

    // Splat persists under arbitrary lane-3 inputs
    for (int k = 0; k < 50; k++) begin
      bus.bump_left[3]  = 1'($urandom);
      bus.bump_right[3] = 1'($urandom);
      bus.ground[3]     = 1'($urandom);
      bus.dig[3]        = 1'($urandom);
      tick();
      check_eq("splat_persist", bus.splat[3], 1);
    end
    bus.bump_left[3] = 1'b0; bus.bump_right[3] = 1'b0;
    bus.ground[3] = 1'b1; bus.dig[3] = 1'b0;

    // Reset mid-fall on lane 2; the next fall counts from 1
    bus.ground[2] = 1'b0;
    ticks(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_mid_fall_wl", bus.walk_left, 4'hF);
    check_eq("rst_mid_fall_alive", bus.alive_cnt, 4);
    ticks(SPLAT_CYCLES);
    bus.ground[2] = 1'b1;
    tick();
    check_eq("refall_survive", bus.walk_left[2], 1);

    // Very long fall: no wrap-around
    bus.ground[3] = 1'b0;
    ticks(300);
    bus.ground[3] = 1'b1;
    tick();
    check_eq("splat_300", bus.splat[3], 1);

    // Random independence run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hole[i] == 0 && $urandom_range(0, 39) == 0) hole[i] = $urandom_range(1, 30);
        bus.ground[i] = (hole[i] == 0);
        if (hole[i] > 0) hole[i]--;
        bus.bump_left[i]  = 1'($urandom);
        bus.bump_right[i] = 1'($urandom);
        bus.dig[i]        = ($urandom_range(0, 15) == 0);
      end
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
